// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit positions,
// the glyph table (a..g, active-low) and the digit-enable helper.
package seven_segment_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam int         PWM_PHASES = 16;

    // Index = nibble value; bit 6 = segment a ... bit 0 = segment g, 0 = lit.
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Pin level for digit `idx` when digit `sel` is the one being driven.
    function automatic logic digit_enable(input logic [2:0] sel, input logic [2:0] idx,
                                          input logic active_low);
        return (sel == idx) ^ active_low;
    endfunction

endpackage

// File: rtl/seven_segment_glyph_rom.sv
// Nibble to seven-segment glyph (a..g, active-low); values above 9 blank unless hex mode.
module seven_segment_glyph_rom (
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    output logic [6:0] o_glyph
);
    import seven_segment_pkg::*;

    always_comb begin
        o_glyph = GLYPH_TABLE[i_nibble];
        if ((i_nibble > 4'd9) && !i_hex_mode) begin
            o_glyph = 7'h7F;
        end
    end

endmodule

// File: rtl/seven_segment_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with guard phase, 16-step PWM,
// hex glyphs and leading-zero suppression; inputs are latched once per frame.
module seven_segment_scan_mux #(
    parameter int N_DIGITS      = 3,
    parameter int TICK_CYCLES   = 1563,
    parameter int EN_ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic [3:0]            i_bright,
    output logic [7:0]            o_seg,
    output logic [N_DIGITS-1:0]   o_digit_en,
    output logic                  o_frame_start
);
    import seven_segment_pkg::*;

    localparam int   TW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int   DW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic EN_LOW = (EN_ACTIVE_LOW != 0);

    logic [TW-1:0]           r_tick;
    logic [3:0]              r_phase;
    logic [DW-1:0]           r_digit;
    logic [4*N_DIGITS-1:0]   r_value;
    logic [N_DIGITS-1:0]     r_dp;
    logic [N_DIGITS-1:0]     r_blank;
    logic                    r_hex_mode;
    logic [3:0]              r_bright;
    logic [7:0]              r_seg;
    logic [N_DIGITS-1:0]     r_digit_en;

    logic                    w_tick_wrap;
    logic                    w_origin;
    logic                    w_lit;
    logic                    w_lz_run;
    logic [N_DIGITS-1:0]     w_blank_mask;
    logic [N_DIGITS-1:0]     w_en_active;
    logic [N_DIGITS-1:0]     w_en_idle;
    logic [3:0]              w_nibble;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg_on;

    assign w_tick_wrap   = (r_tick == TW'(TICK_CYCLES - 1));
    assign w_origin      = (r_digit == '0) && (r_phase == 4'd0) && (r_tick == '0);
    assign o_frame_start = w_origin && i_rst_n;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tick  <= '0;
            r_phase <= 4'd0;
            r_digit <= '0;
        end else if (w_tick_wrap) begin
            r_tick  <= '0;
            r_phase <= r_phase + 4'd1;
            if (r_phase == 4'(PWM_PHASES - 1)) begin
                r_digit <= (r_digit == DW'(N_DIGITS - 1)) ? '0 : r_digit + 1'b1;
            end
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Walk from the most significant digit down; the first nonzero nibble or lit dp ends the run.
    always_comb begin
        w_blank_mask = '0;
        w_lz_run     = i_blank_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (w_lz_run && (i_value[4*i +: 4] == 4'd0) && !i_dp[i]) begin
                w_blank_mask[i] = 1'b1;
            end else begin
                w_lz_run = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_value    <= '0;
            r_dp       <= '0;
            r_blank    <= '0;
            r_hex_mode <= 1'b0;
            r_bright   <= 4'd0;
        end else if (w_origin) begin
            r_value    <= i_value;
            r_dp       <= i_dp;
            r_blank    <= w_blank_mask;
            r_hex_mode <= i_hex_mode;
            r_bright   <= i_bright;
        end
    end

    assign w_nibble = r_value[4*r_digit +: 4];

    seven_segment_glyph_rom u_glyph_rom (
        .i_nibble   (w_nibble),
        .i_hex_mode (r_hex_mode),
        .o_glyph    (w_glyph)
    );

    assign w_seg_on[SEG_A:SEG_G] = w_glyph;
    assign w_seg_on[SEG_DP]      = ~r_dp[r_digit];

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_en
            assign w_en_active[gi] = digit_enable(3'(r_digit), 3'(gi), EN_LOW);
        end
    endgenerate

    assign w_en_idle = {N_DIGITS{EN_LOW}};
    assign w_lit     = (r_phase != 4'd0) && (r_phase <= r_bright);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seg      <= SEG_OFF;
            r_digit_en <= w_en_idle;
        end else if (w_lit) begin
            r_seg      <= r_blank[r_digit] ? SEG_OFF : w_seg_on;
            r_digit_en <= w_en_active;
        end else begin
            r_seg      <= SEG_OFF;
            r_digit_en <= w_en_idle;
        end
    end

    assign o_seg      = r_seg;
    assign o_digit_en = r_digit_en;

endmodule

// File: tb/tb_seven_segment_scan_mux.sv
// Bench for seven_segment_scan_mux: frame-position reference model checked every cycle,
// plus directed literal checks of the display sequence.
module tb_seven_segment_scan_mux;

    localparam int N     = 3;
    localparam int T     = 2;
    localparam int SLOT  = 16 * T;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] value = 12'h123;
    logic [2:0]  dp = 3'b000;
    logic        hex_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'd15;
    logic [7:0]  seg;
    logic [2:0]  en;
    logic        fs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seven_segment_scan_mux #(
        .N_DIGITS      (N),
        .TICK_CYCLES   (T),
        .EN_ACTIVE_LOW (1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_value       (value),
        .i_dp          (dp),
        .i_hex_mode    (hex_mode),
        .i_blank_lz    (blank_lz),
        .i_bright      (bright),
        .o_seg         (seg),
        .o_digit_en    (en),
        .o_frame_start (fs)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Segment pattern a..g for each character, straight from the character shapes.
    function automatic logic [6:0] glyph_of(input logic [3:0] nib, input logic hex);
        case (nib)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
            4'hA: return hex ? 7'b0001000 : 7'h7F;
            4'hB: return hex ? 7'b1100000 : 7'h7F;
            4'hC: return hex ? 7'b0110001 : 7'h7F;
            4'hD: return hex ? 7'b1000010 : 7'h7F;
            4'hE: return hex ? 7'b0110000 : 7'h7F;
            default: return hex ? 7'b0111000 : 7'h7F;
        endcase
    endfunction

    function automatic logic [2:0] lz_mask(input logic [11:0] v, input logic [2:0] dpv, input logic lz);
        logic [2:0] m;
        m = 3'b000;
        if (lz) begin
            for (int i = N - 1; i >= 1; i--) begin
                if (v[4*i +: 4] != 4'd0 || dpv[i]) break;
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Reference model: position within the frame drives everything.
    bit          armed = 0;
    int          pos = 0;
    int          md, mp, act;
    logic [11:0] m_value = '0;
    logic [2:0]  m_dp = '0, m_blank = '0;
    logic        m_hex = 0;
    logic [3:0]  m_bright = '0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [2:0]  exp_en = 3'b111;

    always @(negedge clk) begin
        if (armed) begin
            check("model_seg", seg, exp_seg);
            check("model_en", en, exp_en);
            check("model_frame_start", fs, rst_n && (pos == 0));
            act = 0;
            for (int i = 0; i < N; i++) if (!en[i]) act++;
            check("at_most_one_enable", act <= 1, 1);
        end
        if (!rst_n) begin
            armed    = 1;
            pos      = 0;
            m_value  = '0;
            m_dp     = '0;
            m_blank  = '0;
            m_hex    = 0;
            m_bright = '0;
            exp_seg  = 8'hFF;
            exp_en   = 3'b111;
        end else if (armed) begin
            if (pos == 0) begin
                m_value  = value;
                m_dp     = dp;
                m_hex    = hex_mode;
                m_bright = bright;
                m_blank  = lz_mask(value, dp, blank_lz);
            end
            md = pos / SLOT;
            mp = (pos / T) % 16;
            if (mp == 0 || mp > int'(m_bright)) begin
                exp_seg = 8'hFF;
                exp_en  = 3'b111;
            end else begin
                exp_en  = ~(3'b001 << md);
                exp_seg = m_blank[md] ? 8'hFF : {glyph_of(m_value[4*md +: 4], m_hex), ~m_dp[md]};
            end
            pos = (pos + 1) % FRAME;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns in the frame-start cycle, or records a timeout.
    task automatic next_frame();
        for (int k = 0; k < FRAME + 4; k++) begin
            tick(1);
            if (fs) return;
        end
        check("frame_start_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2);
        next_frame();
        tick(3);
        check({tag, "_d0"}, seg, s0);
        check({tag, "_en0"}, en, 3'b110);
        tick(32);
        check({tag, "_d1"}, seg, s1);
        check({tag, "_en1"}, en, 3'b101);
        tick(32);
        check({tag, "_d2"}, seg, s2);
        check({tag, "_en2"}, en, 3'b011);
    endtask

    int cnt;

    initial begin
        tick(4);
        rst_n = 1'b1;
        #1;
        check("fs_first_cycle", fs, 1);
        check("reset_seg", seg, 8'hFF);
        check("reset_en", en, 3'b111);
        tick(2);
        check("guard_seg", seg, 8'hFF);
        check("guard_en", en, 3'b111);
        tick(1);
        check("digit0_3", seg, 8'h0D);
        check("digit0_en", en, 3'b110);
        tick(32);
        check("digit1_2", seg, 8'h25);
        check("digit1_en", en, 3'b101);
        tick(32);
        check("digit2_1", seg, 8'h9F);
        check("digit2_en", en, 3'b011);
        tick(28);
        check("fs_cycle95", fs, 0);
        tick(1);
        check("fs_period_96", fs, 1);

        value = 12'h007; blank_lz = 1'b1;
        check_frame("lz", 8'h1F, 8'hFF, 8'hFF);
        dp = 3'b010;
        check_frame("lz_dp", 8'h1F, 8'h02, 8'hFF);

        value = 12'h0AF; dp = 3'b000; blank_lz = 1'b0; hex_mode = 1'b0;
        check_frame("hex0", 8'hFF, 8'hFF, 8'h03);
        hex_mode = 1'b1;
        check_frame("hex1", 8'h71, 8'h11, 8'h03);

        bright = 4'd4;
        next_frame();
        tick(10);
        check("bright4_last_on", en, 3'b110);
        tick(1);
        check("bright4_first_off", en, 3'b111);

        bright = 4'd0;
        next_frame();
        cnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick(1);
            if (en != 3'b111) cnt++;
        end
        check("bright0_dark", cnt, 0);
        check("bright0_fs_pulses", fs, 1);

        bright = 4'd15; value = 12'h111; hex_mode = 1'b0;
        next_frame();
        tick(40);
        value = 12'h999;
        cnt = 0;
        for (int k = 0; k < FRAME && !fs; k++) begin
            tick(1);
            if (seg == 8'h19) cnt++;
        end
        check("no_tear_nines", cnt, 0);
        tick(3);
        check("nine_after_latch", seg, 8'h19);

        next_frame();
        tick(20);
        rst_n = 1'b0;
        tick(1);
        check("midreset_seg", seg, 8'hFF);
        check("midreset_en", en, 3'b111);
        check("midreset_bright", dut.r_bright, 0);
        check("midreset_fs_low", fs, 0);
        rst_n = 1'b1;
        #1;
        check("release_fs", fs, 1);

        for (int k = 0; k < 3000; k++) begin
            tick(1);
            if ($urandom_range(0, 39) == 0) begin
                value    = 12'($urandom);
                dp       = 3'($urandom);
                hex_mode = 1'($urandom);
                blank_lz = 1'($urandom);
                bright   = 4'($urandom);
                if ($urandom_range(0, 2) == 0) value[11:4] = 8'h00;
            end
            rst_n = ($urandom_range(0, 999) != 0);
        end
        rst_n = 1'b1;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
